// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD seven-segment display path.
package bin_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns, digit 0 in the least significant slot.
   localparam logic [69:0] SEG_LUT = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

   function automatic int bcd_width(input int digits);
      return 4 * digits;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      if (nib <= 4'd9) begin
         seg = SEG_LUT[7 * int'(nib) +: 7];
      end else begin
         seg = SEG_BLANK;
      end
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; a change on bin_in while idle starts a conversion.
module bin2bcd_seq
   import bin_bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [BIN_W-1:0]               bin_in,
   output logic                           busy,
   output logic                           conv_done,
   output logic [bcd_width(DIGITS)-1:0]   bcd_out
);

   localparam int BCD_W = bcd_width(DIGITS);
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   last_val_q, last_val_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [SR_W-1:0]    adj_s;
   logic [3:0]         nib_s;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
   logic               busy_q, busy_d;
   logic               conv_done_q, conv_done_d;

   always_comb begin
      state_d     = state_q;
      last_val_d  = last_val_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      bcd_out_d   = bcd_out_q;
      conv_done_d = 1'b0;
      adj_s       = sr_q;
      nib_s       = 4'd0;

      // Add-3 correction on every BCD nibble before the shift.
      for (int i = 0; i < DIGITS; i++) begin
         nib_s = sr_q[BIN_W + 4*i +: 4];
         if (nib_s >= 4'd5) begin
            adj_s[BIN_W + 4*i +: 4] = nib_s + 4'd3;
         end else begin
            adj_s[BIN_W + 4*i +: 4] = nib_s;
         end
      end

      case (state_q)
         IDLE: begin
            if (bin_in != last_val_q) begin
               last_val_d = bin_in;
               sr_d       = {{BCD_W{1'b0}}, bin_in};
               cnt_d      = {CNT_W{1'b0}};
               state_d    = SHIFT;
            end else begin
               state_d    = IDLE;
            end
         end
         SHIFT: begin
            sr_d  = {adj_s[SR_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            bcd_out_d   = sr_q[SR_W-1 -: BCD_W];
            conv_done_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_val_q  <= {BIN_W{1'b0}};
         sr_q        <= {SR_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         bcd_out_q   <= {BCD_W{1'b0}};
         busy_q      <= 1'b0;
         conv_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_val_q  <= last_val_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         bcd_out_q   <= bcd_out_d;
         busy_q      <= busy_d;
         conv_done_q <= conv_done_d;
      end
   end

   assign busy      = busy_q;
   assign conv_done = conv_done_q;
   assign bcd_out   = bcd_out_q;

endmodule

// File: rtl/bin_bcd_display.sv
// Binary value to multiplexed active-low seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module bin_bcd_display
   import bin_bcd_pkg::*;
#(
   parameter int BIN_W    = 14,
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BIN_W-1:0]      bin_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy,
   output logic                  conv_done,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int CNT_W = $clog2(SCAN_DIV + 1);
   localparam int SEL_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] bcd_s;
   logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
   logic [SEL_W-1:0]    digit_sel_q, digit_sel_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [3:0]          nib_s;
`ifdef LEADING_ZERO_BLANK_EN
   logic                keep_s;
`endif

   bin2bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_in    (bin_in),
      .busy      (busy),
      .conv_done (conv_done),
      .bcd_out   (bcd_s)
   );

   always_comb begin
      scan_cnt_d  = scan_cnt_q;
      digit_sel_d = digit_sel_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = {CNT_W{1'b0}};
         if (digit_sel_q == SEL_LAST) begin
            digit_sel_d = {SEL_W{1'b0}};
         end else begin
            digit_sel_d = digit_sel_q + SEL_W'(1);
         end
      end else begin
         scan_cnt_d = scan_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      nib_s = 4'd0;
      an_d  = {DIGITS{1'b1}};
`ifdef LEADING_ZERO_BLANK_EN
      keep_s = (digit_sel_q == {SEL_W{1'b0}});
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_sel_q == SEL_W'(i)) begin
            nib_s   = bcd_s[4*i +: 4];
            an_d[i] = 1'b0;
         end else begin
            an_d[i] = 1'b1;
         end
`ifdef LEADING_ZERO_BLANK_EN
         // A nonzero digit at or above the selected one means it is not a leading zero.
         if ((digit_sel_q <= SEL_W'(i)) && (bcd_s[4*i +: 4] != 4'd0)) begin
            keep_s = 1'b1;
         end else begin
            keep_s = keep_s;
         end
`endif
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (keep_s) begin
         seg_d = seg_decode(nib_s);
      end else begin
         seg_d = SEG_BLANK;
      end
`else
      seg_d = seg_decode(nib_s);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt_q  <= {CNT_W{1'b0}};
         digit_sel_q <= {SEL_W{1'b0}};
         seg_q       <= SEG_BLANK;
         an_q        <= {DIGITS{1'b1}};
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         digit_sel_q <= digit_sel_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign bcd_out = bcd_s;
   assign seg     = seg_q;
   assign an      = an_q;

endmodule

// File: tb/tb_bin_bcd_display.sv
// Self-checking bench for bin_bcd_display using a decimal-arithmetic reference model.
module tb_bin_bcd_display;

   localparam int BIN_W    = 14;
   localparam int DIGITS   = 5;
   localparam int SCAN_DIV = 1;
   localparam logic [6:0] SEG_REF [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [BIN_W-1:0]      bin_in = '0;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;
   logic                  conv_done;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     an;

   int checks = 0;
   int errors = 0;
   int cur_val = 0;
   int scan_k = 0;

   bin_bcd_display #(
      .BIN_W    (BIN_W),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_in    (bin_in),
      .bcd_out   (bcd_out),
      .busy      (busy),
      .conv_done (conv_done),
      .seg       (seg),
      .an        (an)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) scan_k <= 0;
      else        scan_k <= scan_k + 1;
   end

   function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
      logic [4*DIGITS-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] ref_seg(input int v, input int d);
      int p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && v < p) return 7'h7F;
`endif
      return SEG_REF[(v / p) % 10];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bin_in = '0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (bcd_out !== '0) begin errors++; $display("FAIL reset_bcd got %h expected 0", bcd_out); end
      checks++; if (an !== 5'b11111) begin errors++; $display("FAIL reset_an got %b expected 11111", an); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b expected 1111111", seg); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (an !== 5'b11110) begin errors++; $display("FAIL first_an got %b expected 11110", an); end
      checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL first_seg got %b expected 1000000", seg); end
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (busy !== 1'b0 || conv_done !== 1'b0 || bcd_out !== '0) begin
            errors++;
            $display("FAIL idle_zero cycle %0d got busy=%b done=%b bcd=%h expected 0/0/0", k, busy, conv_done, bcd_out);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_convert(input int v);
      int hi;
      logic [4*DIGITS-1:0] exp_new;
      logic [4*DIGITS-1:0] exp_old;
      exp_new = ref_bcd(v);
      exp_old = ref_bcd(cur_val);
      @(negedge clk);
      bin_in = BIN_W'(v);
      @(posedge clk); #1;
      hi = (busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= BIN_W; k++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) hi++;
         checks++;
         if (conv_done !== 1'b0 || bcd_out !== exp_old) begin
            errors++;
            $display("FAIL early_update v=%0d cycle %0d got done=%b bcd=%h expected 0/%h", v, k, conv_done, bcd_out, exp_old);
         end
      end
      @(posedge clk); #1;
      checks++; if (bcd_out !== exp_new) begin errors++; $display("FAIL convert v=%0d got %h expected %h", v, bcd_out, exp_new); end
      checks++; if (conv_done !== 1'b1) begin errors++; $display("FAIL done_pulse v=%0d got %b expected 1", v, conv_done); end
      checks++; if (hi != BIN_W) begin errors++; $display("FAIL busy_len v=%0d got %0d expected %0d", v, hi, BIN_W); end
      @(posedge clk); #1;
      checks++; if (conv_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_width v=%0d got done=%b busy=%b expected 0/0", v, conv_done, busy); end
      cur_val = v;
   endtask

   task automatic test_random();
      int v;
      for (int n = 0; n < 8; n++) begin
         v = int'($urandom_range(16383, 1));
         if (v == cur_val) v = (v % 16383) + 1;
         test_convert(v);
      end
   endtask

   task automatic test_back_to_back();
      int np = 0;
      int pc [2];
      logic [4*DIGITS-1:0] pv [2];
      @(negedge clk);
      bin_in = BIN_W'(100);
      @(posedge clk); #1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (conv_done === 1'b1) begin
            if (np < 2) begin pc[np] = k; pv[np] = bcd_out; end
            np++;
         end
         if (k == 5) begin @(negedge clk); bin_in = BIN_W'(42); end
      end
      checks++; if (np != 2) begin errors++; $display("FAIL b2b_count got %0d expected 2", np); end
      if (np >= 2) begin
         checks++; if (pc[0] != 15 || pv[0] !== ref_bcd(100)) begin errors++; $display("FAIL b2b_first got cycle %0d bcd %h expected 15 %h", pc[0], pv[0], ref_bcd(100)); end
         checks++; if (pc[1] != 31 || pv[1] !== ref_bcd(42)) begin errors++; $display("FAIL b2b_second got cycle %0d bcd %h expected 31 %h", pc[1], pv[1], ref_bcd(42)); end
      end
      cur_val = 42;
   endtask

   task automatic test_return_to_last();
      int np = 0;
      @(negedge clk);
      bin_in = BIN_W'(500);
      @(posedge clk); #1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (conv_done === 1'b1) np++;
         if (k == 3) begin @(negedge clk); bin_in = BIN_W'(777); end
         if (k == 6) begin @(negedge clk); bin_in = BIN_W'(500); end
      end
      checks++; if (np != 1) begin errors++; $display("FAIL return_count got %0d expected 1", np); end
      checks++; if (bcd_out !== ref_bcd(500)) begin errors++; $display("FAIL return_bcd got %h expected %h", bcd_out, ref_bcd(500)); end
      cur_val = 500;
   endtask

   task automatic test_scan();
      int d;
      logic [DIGITS-1:0] exp_an;
      logic [6:0] exp_seg;
      test_convert(907);
      repeat (3) @(posedge clk);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         d = (scan_k - 1) % DIGITS;
         exp_an = ~(DIGITS'(1) << d);
         exp_seg = ref_seg(907, d);
         checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an digit %0d got %b expected %b", d, an, exp_an); end
         checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg digit %0d got %b expected %b", d, seg, exp_seg); end
      end
   endtask

   task automatic test_reset_mid();
      int np = 0;
      int pc = 0;
      @(negedge clk);
      bin_in = BIN_W'(3210);
      @(posedge clk); #1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || bcd_out !== '0 || conv_done !== 1'b0 || an !== 5'b11111 || seg !== 7'h7F) begin
         errors++;
         $display("FAIL mid_reset got busy=%b bcd=%h done=%b an=%b seg=%b expected 0/00000/0/11111/1111111", busy, bcd_out, conv_done, an, seg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reconvert_start got busy=%b expected 1", busy); end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (conv_done === 1'b1) begin np++; pc = k; end
      end
      checks++; if (np != 1 || pc != 15) begin errors++; $display("FAIL reconvert_done got %0d pulses at %0d expected 1 at 15", np, pc); end
      checks++; if (bcd_out !== ref_bcd(3210)) begin errors++; $display("FAIL reconvert_bcd got %h expected %h", bcd_out, ref_bcd(3210)); end
      cur_val = 3210;
   endtask

   initial begin
      test_reset();
      test_convert(12345);
      test_convert(16383);
      test_convert(9999);
      test_random();
      test_back_to_back();
      test_return_to_last();
      test_scan();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin_bcd_display.md
Name: bin_bcd_display

Overview:
- Downstream stage of the keypad number-entry block: consumes its registered 14-bit binary result and drives a multiplexed 5-digit seven-segment display.
- A sequential double-dabble converter turns the binary value into BCD.
- A scan counter time-multiplexes the digits, with active-low segment and anode outputs.
- Conversion starts automatically whenever the binary input changes, because the upstream block provides no strobe.

Parameters:
- BIN_W, 14, binary input width.
- DIGITS, 5, BCD digits and display positions. Must satisfy 10^DIGITS > 2^BIN_W.
- SCAN_DIV, 50000, clocks per digit slot. Legal range is 1 or more; 1 advances the digit every cycle.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- bin_in  in  BIN_W  binary value from the upstream entry block.
- bcd_out  out  4*DIGITS  last converted value; nibble 0 is the units digit.
- busy  out  1  high while the converter is in SHIFT.
- conv_done  out  1  one-cycle pulse when bcd_out updates.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, last_val=0, shift register=0, bit counter=0.
  - bcd_out=0, busy=0, conv_done=0.
  - scan_cnt=0, digit_sel=0.
  - seg=7'h7F, an=all ones.
  - Reset mid-conversion aborts the conversion with no partial update.
- IDLE: if bin_in != last_val at a posedge:
  - capture last_val<=bin_in;
  - load shift register {BCD=0, BIN=bin_in};
  - cnt<=0; go to SHIFT.
- SHIFT:
  - Each cycle, every BCD nibble >=5 gets +3, then the whole register shifts left by 1.
  - cnt increments; after BIN_W cycles go to DONE.
  - busy=1 throughout SHIFT, exactly BIN_W cycles.
  - Changes on bin_in are ignored while in SHIFT.
- DONE:
  - bcd_out<=BCD field; conv_done=1 for this single cycle; next state IDLE.
  - In IDLE, a pending change (bin_in != last_val) launches a new conversion immediately.
- Latency: bcd_out holds the new value BIN_W+1 clocks after the capture edge (15 clocks at default width).
- If bin_in returns to last_val during SHIFT, no further conversion is started.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1; on wrap, digit_sel increments modulo DIGITS.
  - an and seg are registered one cycle after digit_sel/bcd_out.
  - an[digit_sel]=0, all other bits 1.
  - seg is the decode of nibble digit_sel.
  - Nibble codes 10..15 cannot occur; the decoder maps them to blank (7'h7F).
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- A bcd_out update takes effect on the display starting with the slot of the next registered seg.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit shows seg=7'h7F while its an still scans normally. Digit 0 is never blanked, so value 0 shows "0".
- Undefined: all DIGITS positions show their decoded value, including leading zeros.

Decomposition:
- Package bin_bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - SEG_BLANK = 7'h7F;
  - 10-entry segment lookup constant;
  - localparam-style helper for BCD width.
- Sub-module bin2bcd_seq holds the double-dabble FSM (bin_in, start detect, busy, conv_done, bcd_out).
- The top level keeps the scan counter, digit mux and segment decode.

Test Plan:
1. Reset release with bin_in=0 -> no conversion ever starts; busy=0, bcd_out=0. One cycle after scan starts: an=11110, seg=1000000.
2. bin_in 0->12345 -> busy high for exactly 14 cycles; bcd_out=20'h12345 and conv_done=1 on clock 15 after the capture edge.
3. bin_in=16383 (max) -> bcd_out=20'h16383; 9999 -> 20'h09999.
4. bin_in=100, then 42 applied 5 cycles later (mid-SHIFT) -> bcd_out=20'h00100 with one conv_done, then a second conversion, bcd_out=20'h00042, with a second conv_done.
5. SCAN_DIV=1, bcd_out=20'h00907:
   - an cycles 11110,11101,11011,10111,01111;
   - seg 1111000, 1000000, 0010000, then digits 3-4 show 1000000;
   - with LEADING_ZERO_BLANK_EN, digits 3-4 show 1111111.
6. rst_n low at SHIFT cycle 7 -> next cycle busy=0, bcd_out=0, an=11111, seg=7'h7F; after release, a bin_in value still nonzero is re-converted.
